// File: rtl/stu_pkg.sv
// Shared types and helpers for the store unit: op/AMO encodings, size and AMO decode, exception causes.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stu_pkg;

    typedef enum logic [3:0] {
        STU_SB        = 4'd0,
        STU_SH        = 4'd1,
        STU_SW        = 4'd2,
        STU_SD        = 4'd3,
        STU_AMOADD_W  = 4'd4,
        STU_AMOADD_D  = 4'd5,
        STU_AMOSWAP_W = 4'd6,
        STU_AMOSWAP_D = 4'd7
    } stu_op_t;

    typedef enum logic [1:0] {
        AMO_NONE = 2'd0,
        AMO_ADD  = 2'd1,
        AMO_SWAP = 2'd2
    } amo_t;

    localparam logic [5:0] CAUSE_ILLEGAL_INSTR = 6'd2;
    localparam logic [5:0] CAUSE_ST_MISALIGNED = 6'd6;

    // log2 of the access size in bytes: 0=byte .. 3=doubleword
    function automatic logic [1:0] op_size(input stu_op_t op);
        case (op)
            STU_SB:                       return 2'd0;
            STU_SH:                       return 2'd1;
            STU_SW, STU_AMOADD_W,
            STU_AMOSWAP_W:                return 2'd2;
            default:                      return 2'd3;
        endcase
    endfunction

    function automatic logic op_is_amo(input stu_op_t op);
        return op inside {STU_AMOADD_W, STU_AMOADD_D, STU_AMOSWAP_W, STU_AMOSWAP_D};
    endfunction

    function automatic amo_t op_amo(input stu_op_t op);
        case (op)
            STU_AMOADD_W, STU_AMOADD_D:   return AMO_ADD;
            STU_AMOSWAP_W, STU_AMOSWAP_D: return AMO_SWAP;
            default:                      return AMO_NONE;
        endcase
    endfunction

    // An access is misaligned when any address bit below its size is set
    function automatic logic is_misaligned(input logic [2:0] lsb, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lsb[0];
            2'd2:    return |lsb[1:0];
            default: return |lsb[2:0];
        endcase
    endfunction

endpackage

// File: rtl/stu_req_fifo.sv
// Circular request FIFO of DEPTH entries with flush and occupancy count.
// Latency: a pushed entry is visible at data_o the cycle after the push.
// Backpressure: full_o refuses pushes (even with a same-cycle pop); flush_i clears and overrides push/pop.
// Ports: clk_i/rst_ni, flush_i, push_i/data_i, pop_i, data_o (head), full_o, count_o.
module stu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = push_i & ~w_full & ~flush_i;
    assign w_pop   = pop_i & (r_count != '0) & ~flush_i;
    assign full_o  = w_full;
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/store_unit_mq.sv
// Store front-end: queues in-order store/AMO requests, translates the head, aligns data, issues to store buffer/AMO path.
// Latency: push at t, DTLB hit at t+1, issue handshake and writeback at t+2 at the earliest.
// Backpressure: ready_o drops when the queue is full; issue holds a stable payload until sb_ready_i/amo_ready_i.
// Ports: request (valid_i/ready_o, op/vaddr/data/be/trans_id), DTLB (translation_req_o, vaddr_o, hit/paddr/ex),
//        store buffer (sb_*), AMO path (amo_*, only with STU_AMO_EN defined), writeback (wb_*, no backpressure).
// Build option: STU_AMO_EN routes AMOs through amo_valid_o/amo_ready_i; otherwise AMOs write back illegal-instruction.
module store_unit_mq
    import stu_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int VLEN          = 39,
    parameter int PLEN          = 56,
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  stu_op_t                  op_i,
    input  logic [VLEN-1:0]          vaddr_i,
    input  logic [XLEN-1:0]          data_i,
    input  logic [XLEN/8-1:0]        be_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     translation_req_o,
    output logic [VLEN-1:0]          vaddr_o,
    input  logic                     dtlb_hit_i,
    input  logic [PLEN-1:0]          paddr_i,
    input  logic                     ex_valid_i,
    input  logic [5:0]               ex_cause_i,
    output logic                     sb_valid_o,
    input  logic                     sb_ready_i,
    output logic [PLEN-1:0]          sb_paddr_o,
    output logic [XLEN-1:0]          sb_data_o,
    output logic [XLEN/8-1:0]        sb_be_o,
    output logic [1:0]               sb_size_o,
`ifdef STU_AMO_EN
    output logic                     amo_valid_o,
    input  logic                     amo_ready_i,
    output amo_t                     amo_op_o,
`endif
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic                     wb_ex_valid_o,
    output logic [5:0]               wb_ex_cause_o
);

    localparam int AW = $clog2(XLEN / 8);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        stu_op_t                  op;
        logic [VLEN-1:0]          vaddr;
        logic [XLEN-1:0]          data;
        logic [XLEN/8-1:0]        be;
        logic [TRANS_ID_BITS-1:0] id;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_XLATE, S_ISSUE} state_t;

    state_t          r_state;
    logic [PLEN-1:0] r_paddr;

    req_t            w_req_in;
    req_t            w_head;
    logic            w_full;
    logic [CW-1:0]   w_count;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_is_amo;
    logic            w_illegal;
    logic            w_misal;
    logic            w_amo_wait;
    logic            w_in_xlate;
    logic            w_in_issue;
    logic            w_xlate_wb;
    logic            w_hs;
    logic [XLEN-1:0] w_shift_data;
    logic [XLEN-1:0] w_issue_data;

    assign w_req_in.op    = op_i;
    assign w_req_in.vaddr = vaddr_i;
    assign w_req_in.data  = data_i;
    assign w_req_in.be    = be_i;
    assign w_req_in.id    = trans_id_i;

    stu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (valid_i),
        .data_i  (w_req_in),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .count_o (w_count)
    );

    assign ready_o    = ~w_full;
    assign w_push_ok  = valid_i & ~w_full & ~flush_i;
    assign w_in_xlate = (r_state == S_XLATE);
    assign w_in_issue = (r_state == S_ISSUE) & ~flush_i;
    assign w_is_amo   = op_is_amo(w_head.op);
    assign w_misal    = is_misaligned(w_head.vaddr[2:0], op_size(w_head.op));

`ifdef STU_AMO_EN
    // A head AMO is held in XLATE until the AMO path can take it, so only one is ever in flight
    assign w_illegal   = 1'b0;
    assign w_amo_wait  = w_is_amo & ~amo_ready_i;
    assign amo_valid_o = w_in_issue & w_is_amo;
    assign amo_op_o    = amo_valid_o ? op_amo(w_head.op) : AMO_NONE;
    assign sb_valid_o  = w_in_issue & ~w_is_amo;
    assign w_hs        = (sb_valid_o & sb_ready_i) | (amo_valid_o & amo_ready_i);
    assign w_issue_data = w_is_amo ? w_head.data : w_shift_data;
`else
    assign w_illegal   = w_is_amo;
    assign w_amo_wait  = 1'b0;
    assign sb_valid_o  = w_in_issue;
    assign w_hs        = sb_valid_o & sb_ready_i;
    assign w_issue_data = w_shift_data;
`endif

    // Illegal and misaligned heads complete without ever asking the DTLB
    assign translation_req_o = w_in_xlate & ~w_illegal & ~w_misal & ~w_amo_wait;
    assign vaddr_o           = w_in_xlate ? w_head.vaddr : '0;

    assign w_xlate_wb = ~flush_i & w_in_xlate &
                        (w_illegal | w_misal | (translation_req_o & ex_valid_i));

    // Every writeback retires the head entry
    assign w_pop         = wb_valid_o;
    assign wb_valid_o    = w_xlate_wb | w_hs;
    assign wb_ex_valid_o = w_xlate_wb;
    assign wb_trans_id_o = wb_valid_o ? w_head.id : '0;
    assign wb_ex_cause_o = !w_xlate_wb ? 6'd0 :
                           w_illegal   ? CAUSE_ILLEGAL_INSTR :
                           w_misal     ? CAUSE_ST_MISALIGNED : ex_cause_i;

    // Store data is right-justified on entry; move it to its byte lane
    assign w_shift_data = w_head.data << {w_head.vaddr[AW-1:0], 3'b000};

    // Payload is zero outside ISSUE so idle outputs stay quiet
    assign sb_paddr_o = (r_state == S_ISSUE) ? r_paddr : '0;
    assign sb_data_o  = (r_state == S_ISSUE) ? w_issue_data : '0;
    assign sb_be_o    = (r_state == S_ISSUE) ? w_head.be : '0;
    assign sb_size_o  = (r_state == S_ISSUE) ? op_size(w_head.op) : 2'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_paddr <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Entering on the push itself gives the head a DTLB lookup the next cycle
                    if (w_count != '0 || w_push_ok) r_state <= S_XLATE;
                end
                S_XLATE: begin
                    if (w_xlate_wb) begin
                        r_state <= S_IDLE;
                    end else if (translation_req_o && dtlb_hit_i) begin
                        r_paddr <= paddr_i;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_hs) r_state <= (w_count > CW'(1)) ? S_XLATE : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit_mq.sv
// Self-checking bench for store_unit_mq: directed stimulus, expectations queued at issue, monitor compares at outputs.
// Latency: n/a.
// Backpressure: bench drives sb_ready_i and DTLB hits to exercise stalls, full queue and flush.
module tb_store_unit_mq;
    import stu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    stu_op_t     op_i;
    logic [38:0] vaddr_i;
    logic [63:0] data_i;
    logic [7:0]  be_i;
    logic [2:0]  trans_id_i;
    logic        translation_req_o;
    logic [38:0] vaddr_o;
    logic        dtlb_hit_i;
    logic [55:0] paddr_i;
    logic        ex_valid_i;
    logic [5:0]  ex_cause_i;
    logic        sb_valid_o;
    logic        sb_ready_i;
    logic [55:0] sb_paddr_o;
    logic [63:0] sb_data_o;
    logic [7:0]  sb_be_o;
    logic [1:0]  sb_size_o;
`ifdef STU_AMO_EN
    logic        amo_valid_o;
    logic        amo_ready_i;
    amo_t        amo_op_o;
`endif
    logic        wb_valid_o;
    logic [2:0]  wb_trans_id_o;
    logic        wb_ex_valid_o;
    logic [5:0]  wb_ex_cause_o;

    // DTLB model: fixed mapping, hit/exception gated by the bench
    logic        tlb_en;
    logic        ex_en;
    logic [38:0] ex_va;
    assign paddr_i    = {1'b1, 16'h0000, vaddr_o};
    assign dtlb_hit_i = tlb_en & translation_req_o;
    assign ex_valid_i = ex_en & translation_req_o & (vaddr_o == ex_va);
    assign ex_cause_i = 6'd15;

    store_unit_mq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i), .vaddr_i(vaddr_i),
        .data_i(data_i), .be_i(be_i), .trans_id_i(trans_id_i),
        .translation_req_o(translation_req_o), .vaddr_o(vaddr_o),
        .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i),
        .ex_valid_i(ex_valid_i), .ex_cause_i(ex_cause_i),
        .sb_valid_o(sb_valid_o), .sb_ready_i(sb_ready_i), .sb_paddr_o(sb_paddr_o),
        .sb_data_o(sb_data_o), .sb_be_o(sb_be_o), .sb_size_o(sb_size_o),
`ifdef STU_AMO_EN
        .amo_valid_o(amo_valid_o), .amo_ready_i(amo_ready_i), .amo_op_o(amo_op_o),
`endif
        .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
        .wb_ex_valid_o(wb_ex_valid_o), .wb_ex_cause_o(wb_ex_cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [55:0] paddr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [1:0]  size;
    } sb_exp_t;

    typedef struct {
        logic [2:0] id;
        logic       ex;
        logic [5:0] cause;
    } wb_exp_t;

    sb_exp_t sbq[$];
    wb_exp_t wbq[$];
    int      n_chk;
    int      n_fail;
    logic    saw_treq;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_sb(input logic [55:0] pa, input logic [63:0] d, input logic [7:0] be, input logic [1:0] sz);
        sb_exp_t e;
        e.paddr = pa; e.data = d; e.be = be; e.size = sz;
        sbq.push_back(e);
    endtask

    task automatic exp_wb(input logic [2:0] id, input logic ex, input logic [5:0] cause);
        wb_exp_t e;
        e.id = id; e.ex = ex; e.cause = cause;
        wbq.push_back(e);
    endtask

    // Presents one request for one cycle; caller is positioned just after a rising edge
    task automatic push(input stu_op_t op, input logic [38:0] va, input logic [63:0] d,
                        input logic [7:0] be, input logic [2:0] id);
        valid_i = 1'b1; op_i = op; vaddr_i = va; data_i = d; be_i = be; trans_id_i = id;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 80 && (wbq.size() != 0 || sbq.size() != 0); k++) @(negedge clk_i);
        chk(nm, 64'(wbq.size() + sbq.size()), 64'd0);
    endtask

    task automatic monitor();
        wb_exp_t w;
        sb_exp_t s;
        logic    issue_hs;
        forever begin
            @(negedge clk_i);
            if (translation_req_o) saw_treq = 1'b1;
            issue_hs = sb_valid_o & sb_ready_i;
`ifdef STU_AMO_EN
            issue_hs = issue_hs | (amo_valid_o & amo_ready_i);
`endif
            if (issue_hs) begin
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_unexpected: got paddr %0h expected no issue", sb_paddr_o);
                end else begin
                    s = sbq.pop_front();
                    chk("sb_paddr", 64'(sb_paddr_o), 64'(s.paddr));
                    chk("sb_data",  sb_data_o, s.data);
                    chk("sb_be",    64'(sb_be_o), 64'(s.be));
                    chk("sb_size",  64'(sb_size_o), 64'(s.size));
                end
            end
            if (wb_valid_o) begin
                if (wbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wb_unexpected: got id %0d expected no writeback", wb_trans_id_o);
                end else begin
                    w = wbq.pop_front();
                    chk("wb_id",    64'(wb_trans_id_o), 64'(w.id));
                    chk("wb_ex",    64'(wb_ex_valid_o), 64'(w.ex));
                    chk("wb_cause", 64'(wb_ex_cause_o), 64'(w.cause));
                end
            end
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; saw_treq = 1'b0;
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; op_i = STU_SB;
        vaddr_i = '0; data_i = '0; be_i = '0; trans_id_i = '0;
        sb_ready_i = 1'b0; tlb_en = 1'b0; ex_en = 1'b0; ex_va = '0;
`ifdef STU_AMO_EN
        amo_ready_i = 1'b1;
`endif
        fork
            monitor();
            begin
                #400000;
                $display("FAIL timeout: simulation did not complete");
                $fatal(1);
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_ready",    64'(ready_o), 64'd1);
        chk("rst_sb_valid", 64'(sb_valid_o), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_treq",     64'(translation_req_o), 64'd0);
        chk("rst_sb_data",  sb_data_o, 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // SW at 0x1004: lookup at t+1, issue+writeback at t+2, data moved to lane 4
        tlb_en = 1'b1; sb_ready_i = 1'b1;
        exp_sb(56'h80_0000_0000_1004, 64'h0000_00AB_0000_0000, 8'hF0, 2'd2);
        exp_wb(3'd1, 1'b0, 6'd0);
        push(STU_SW, 39'h1004, 64'hAB, 8'hF0, 3'd1);
        @(negedge clk_i);
        chk("lat_treq_t1", 64'(translation_req_o), 64'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("lat_sb_t2", 64'(sb_valid_o), 64'd1);
        chk("lat_wb_t2", 64'(wb_valid_o), 64'd1);
        drain("single_drain");

        // Byte and halfword lane alignment
        @(posedge clk_i); #1;
        exp_sb(56'h80_0000_0000_6003, 64'h0000_0000_5A00_0000, 8'h08, 2'd0);
        exp_wb(3'd1, 1'b0, 6'd0);
        push(STU_SB, 39'h6003, 64'h5A, 8'h08, 3'd1);
        exp_sb(56'h80_0000_0000_6006, 64'hBEEF_0000_0000_0000, 8'hC0, 2'd1);
        exp_wb(3'd2, 1'b0, 6'd0);
        push(STU_SH, 39'h6006, 64'hBEEF, 8'hC0, 3'd2);
        drain("align_drain");

        // Fill with no hits: 4 accepted, 5th refused, then in-order release
        @(posedge clk_i); #1;
        tlb_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; op_i = STU_SD; vaddr_i = 39'h2000 + 39'(8 * i);
            data_i = 64'(i + 1); be_i = 8'hFF; trans_id_i = 3'(i);
            @(negedge clk_i);
            chk("fill_ready", 64'(ready_o), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) begin
                exp_sb({1'b1, 16'h0000, 39'h2000 + 39'(8 * i)}, 64'(i + 1), 8'hFF, 2'd3);
                exp_wb(3'(i), 1'b0, 6'd0);
            end
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("full_ready", 64'(ready_o), 64'd0);
        @(posedge clk_i); #1;
        tlb_en = 1'b1;
        drain("fill_drain");

        // Misaligned SW: cause 6 without any DTLB request
        @(posedge clk_i); #1;
        saw_treq = 1'b0;
        exp_wb(3'd5, 1'b1, CAUSE_ST_MISALIGNED);
        push(STU_SW, 39'h1002, 64'h77, 8'h0C, 3'd5);
        drain("misal_drain");
        repeat (3) @(negedge clk_i);
        chk("misal_no_treq", 64'(saw_treq), 64'd0);

        // Translation exception on head, next entry still issues
        @(posedge clk_i); #1;
        ex_en = 1'b1; ex_va = 39'h3000;
        exp_wb(3'd6, 1'b1, 6'd15);
        push(STU_SD, 39'h3000, 64'h11, 8'hFF, 3'd6);
        exp_sb(56'h80_0000_0000_3008, 64'h22, 8'hFF, 2'd3);
        exp_wb(3'd7, 1'b0, 6'd0);
        push(STU_SD, 39'h3008, 64'h22, 8'hFF, 3'd7);
        drain("ex_drain");
        ex_en = 1'b0;

        // AMOADD.D at head
        @(posedge clk_i); #1;
`ifdef STU_AMO_EN
        exp_sb(56'h80_0000_0000_5000, 64'h1234, 8'hFF, 2'd3);
        exp_wb(3'd4, 1'b0, 6'd0);
`else
        exp_wb(3'd4, 1'b1, CAUSE_ILLEGAL_INSTR);
`endif
        push(STU_AMOADD_D, 39'h5000, 64'h1234, 8'hFF, 3'd4);
        drain("amo_drain");

        // Flush while stalled in issue with 3 queued: nothing written back
        @(posedge clk_i); #1;
        sb_ready_i = 1'b0;
        push(STU_SD, 39'h4000, 64'h1, 8'hFF, 3'd1);
        push(STU_SD, 39'h4008, 64'h2, 8'hFF, 3'd2);
        push(STU_SD, 39'h4010, 64'h3, 8'hFF, 3'd3);
        begin
            int k;
            for (k = 0; k < 20 && !sb_valid_o; k++) @(negedge clk_i);
            chk("flush_reach_issue", 64'(sb_valid_o), 64'd1);
        end
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_sb_valid", 64'(sb_valid_o), 64'd0);
        chk("flush_wb_valid", 64'(wb_valid_o), 64'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0; sb_ready_i = 1'b1;
        @(negedge clk_i);
        chk("post_flush_ready", 64'(ready_o), 64'd1);
        chk("post_flush_treq",  64'(translation_req_o), 64'd0);
        repeat (10) @(negedge clk_i);

        chk("final_wbq_empty", 64'(wbq.size()), 64'd0);
        chk("final_sbq_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
